// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: HH:MM:SS BCD timekeeper with debounced mode/inc keys, auto-repeat and RUN/SET_H/SET_M/SET_S control.
module clock_time_ctrl #(
  parameter int DEB_SAMPLES    = 3,
  parameter int HOLD_SAMPLES   = 50,
  parameter int REPEAT_SAMPLES = 10
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       clk_100Hz,
  input  logic       clk_1Hz,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic [2:0] blink_mask,
  output logic       sec_tick
);
  localparam int DW = $clog2(DEB_SAMPLES + 1);
  localparam int RW = $clog2((HOLD_SAMPLES > REPEAT_SAMPLES ? HOLD_SAMPLES : REPEAT_SAMPLES) + 1);

  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;

  state_t             state_q, state_d;
  logic               c100_q, c1_q, p100, p1;
  logic [1:0]         s1_q, s2_q, stable_q, stable_d, arm_q, arm_d, press;
  logic [1:0][DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0]      rcnt_q, rcnt_d;
  logic               rep_q, rep_d, rep_ev, mode_ev, inc_ev;
  logic [7:0]         hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [2:0]         blink_q, blink_d;
  logic               tick_q, tick_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    return v == lim ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign p100 = clk_100Hz & ~c100_q;
  assign p1   = clk_1Hz & ~c1_q;

  // bit 0 = mode key, bit 1 = inc key; arm blocks events from a key held since reset
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = dcnt_q;
    arm_d    = arm_q;
    press    = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (p100) begin
        arm_d[k] = arm_q[k] | ~s2_q[k];
        if (s2_q[k] == stable_q[k]) dcnt_d[k] = '0;
        else if (dcnt_q[k] + 1'b1 == DW'(DEB_SAMPLES)) begin
          stable_d[k] = ~stable_q[k];
          dcnt_d[k]   = '0;
          press[k]    = ~stable_q[k] & arm_q[k];
        end else dcnt_d[k] = dcnt_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    rcnt_d = rcnt_q;
    rep_d  = rep_q;
    rep_ev = 1'b0;
    if (press[1] | ~stable_d[1]) begin
      rcnt_d = '0;
      rep_d  = 1'b0;
    end else if (p100 & arm_q[1]) begin
      rcnt_d = rcnt_q + 1'b1;
      if (rcnt_d == (rep_q ? RW'(REPEAT_SAMPLES) : RW'(HOLD_SAMPLES))) begin
        rep_ev = 1'b1;
        rcnt_d = '0;
        rep_d  = 1'b1;
      end
    end
  end

  assign mode_ev = press[0];
  assign inc_ev  = (press[1] | rep_ev) & ~mode_ev;

  always_comb begin
    state_d = mode_ev ? state_t'(state_q + 2'd1) : state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (state_q == RUN && p1) begin
      sec_d = bcd_inc(sec_q, 8'h59);
      if (sec_q == 8'h59) begin
        min_d = bcd_inc(min_q, 8'h59);
        if (min_q == 8'h59) hour_d = bcd_inc(hour_q, 8'h23);
      end
    end
    if (inc_ev && state_q == SET_H) hour_d = bcd_inc(hour_q, 8'h23);
    if (inc_ev && state_q == SET_M) min_d = bcd_inc(min_q, 8'h59);
    if (inc_ev && state_q == SET_S) sec_d = 8'h00;
    blink_d = {state_d == SET_H, state_d == SET_M, state_d == SET_S} & {3{clk_1Hz}};
    tick_d  = state_q == RUN && p1;
  end

  // synchronizers reset to "pressed" so a key held through reset cannot arm early
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      c100_q   <= 1'b0;
      c1_q     <= 1'b0;
      s1_q     <= 2'b11;
      s2_q     <= 2'b11;
      stable_q <= 2'b00;
      arm_q    <= 2'b00;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      rep_q    <= 1'b0;
      hour_q   <= 8'h00;
      min_q    <= 8'h00;
      sec_q    <= 8'h00;
      blink_q  <= 3'b000;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c100_q   <= clk_100Hz;
      c1_q     <= clk_1Hz;
      s1_q     <= {~key_inc_n, ~key_mode_n};
      s2_q     <= s1_q;
      stable_q <= stable_d;
      arm_q    <= arm_d;
      dcnt_q   <= dcnt_d;
      rcnt_q   <= rcnt_d;
      rep_q    <= rep_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      blink_q  <= blink_d;
      tick_q   <= tick_d;
    end
  end

  assign hour_bcd   = hour_q;
  assign min_bcd    = min_q;
  assign sec_bcd    = sec_q;
  assign mode       = state_q;
  assign blink_mask = blink_q;
  assign sec_tick   = tick_q;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: scoreboard bench for clock_time_ctrl with a seconds-of-day model and key stimulus tasks.
module tb_clock_time_ctrl;
  localparam int DEB = 3, HOLD = 50, REP = 10;
  logic       sys_clk = 0, rst_n = 0, clk_100Hz = 0, clk_1Hz = 0, key_mode_n = 1, key_inc_n = 1;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] mode;
  logic [2:0] blink_mask;
  logic       sec_tick;
  int         n_cmp = 0, n_err = 0, n_tick = 0, eh = 0, em = 0, es = 0, ev = 0;
  logic [23:0] exp_q[$];

  clock_time_ctrl #(.DEB_SAMPLES(DEB), .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(REP)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .clk_100Hz(clk_100Hz), .clk_1Hz(clk_1Hz),
    .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
    .sec_bcd(sec_bcd), .mode(mode), .blink_mask(blink_mask), .sec_tick(sec_tick));

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic logic [23:0] exp_time();
    return {bcd(eh), bcd(em), bcd(es)};
  endfunction

  always @(posedge sys_clk) begin
    #1;
    if (sec_tick) begin
      n_tick++;
      if (exp_q.size() == 0) check("tick_unexpected", 1, 0);
      else check("tick_time", {hour_bcd, min_bcd, sec_bcd}, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic p100();
    clk_100Hz = 1;
    cyc(2);
    clk_100Hz = 0;
    cyc(2);
  endtask

  task automatic tick(input bit run);
    clk_1Hz = 1;
    if (run) begin
      es++;
      if (es == 60) begin
        es = 0;
        em++;
        if (em == 60) begin
          em = 0;
          eh = (eh + 1) % 24;
        end
      end
      exp_q.push_back(exp_time());
    end
    @(posedge sys_clk);
    #1 check("tick_lat", sec_tick, run);
    @(posedge sys_clk);
    #1 check("tick_width", sec_tick, 0);
    @(negedge sys_clk);
    clk_1Hz = 0;
    cyc(1);
  endtask

  task automatic keys(input bit m, input bit i, input int n);
    key_mode_n = ~m;
    key_inc_n  = ~i;
    cyc(3);
    repeat (n) p100();
    key_mode_n = 1;
    key_inc_n  = 1;
    cyc(3);
    repeat (4) p100();
  endtask

  task automatic incs(input int n);
    repeat (n) keys(0, 1, DEB);
  endtask

  initial begin
    cyc(3);
    check("rst_time", {hour_bcd, min_bcd, sec_bcd}, 0);
    check("rst_mode", mode, 0);
    check("rst_blink", blink_mask, 0);
    check("rst_tick", sec_tick, 0);
    rst_n = 1;
    cyc(3);
    repeat (2) p100();
    repeat (3661) tick(1);
    check("t1_time", {hour_bcd, min_bcd, sec_bcd}, 24'h010101);
    check("t1_ticks", n_tick, 3661);
    check("t1_queue", exp_q.size(), 0);
    incs(1);
    check("run_inc_ignored", {hour_bcd, min_bcd, sec_bcd}, 24'h010101);
    keys(1, 0, DEB - 1);
    check("deb_short", mode, 0);
    keys(1, 0, DEB);
    check("deb_mode", mode, 1);
    clk_1Hz = 1;
    cyc(2);
    check("blink_h_on", blink_mask, 3'b100);
    clk_1Hz = 0;
    cyc(2);
    check("blink_h_off", blink_mask, 3'b000);
    incs(22);
    check("set_h23", hour_bcd, 8'h23);
    incs(1);
    check("h_wrap", hour_bcd, 8'h00);
    incs(23);
    check("set_h23_again", hour_bcd, 8'h23);
    keys(1, 0, DEB);
    check("mode_set_m", mode, 2);
    incs(58);
    check("set_m59", min_bcd, 8'h59);
    incs(1);
    check("m_wrap", min_bcd, 8'h00);
    check("m_wrap_hour", hour_bcd, 8'h23);
    incs(59);
    repeat (5) tick(0);
    check("set_frozen", {hour_bcd, min_bcd, sec_bcd}, 24'h235901);
    keys(1, 0, DEB);
    check("mode_set_s", mode, 3);
    incs(1);
    check("set_s_zero", {hour_bcd, min_bcd, sec_bcd}, 24'h235900);
    keys(1, 0, DEB);
    check("mode_run", mode, 0);
    eh = 23; em = 59; es = 0;
    repeat (59) tick(1);
    check("t2_235959", {hour_bcd, min_bcd, sec_bcd}, 24'h235959);
    tick(1);
    check("t2_rollover", {hour_bcd, min_bcd, sec_bcd}, 24'h000000);
    check("t2_queue", exp_q.size(), 0);
    keys(1, 0, DEB);
    keys(1, 0, DEB);
    check("t5_mode", mode, 2);
    for (int i = 1; i <= 100; i++)
      if (i == DEB || (i >= DEB + HOLD && (i - DEB - HOLD) % REP == 0)) ev++;
    keys(0, 1, 100);
    check("t5_repeat_min", min_bcd, bcd(ev));
    check("t5_hour", hour_bcd, 8'h00);
    keys(1, 0, DEB);
    keys(1, 0, DEB);
    keys(1, 0, DEB);
    check("t6_set_h", mode, 1);
    keys(1, 1, DEB);
    check("t6_both_mode", mode, 2);
    check("t6_both_hour", hour_bcd, 8'h00);
    incs(1);
    check("t6_min", min_bcd, bcd(ev + 1));
    key_mode_n = 0;
    key_inc_n  = 0;
    cyc(3);
    repeat (2) p100();
    #2 rst_n = 0;
    #1 check("t6_rst_time", {hour_bcd, min_bcd, sec_bcd}, 0);
    check("t6_rst_mode", mode, 0);
    cyc(2);
    rst_n = 1;
    cyc(3);
    repeat (6) p100();
    check("t6_held_no_event", mode, 0);
    key_mode_n = 1;
    key_inc_n  = 1;
    cyc(3);
    repeat (4) p100();
    keys(1, 0, DEB);
    check("t6_repress", mode, 1);
    check("t6_post_time", {hour_bcd, min_bcd, sec_bcd}, 0);
    check("final_ticks", n_tick, 3661 + 60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
